cprv_mem_stage: RTL
===================

CPRV_MEM_STAGE -- requirements
Module: cprv_mem_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the register and data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, meaning the data-memory address width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have these upstream (execute) ports:
- valid_mem_i  in  1  execute result valid
- ready_mem_o  out  1  stage can accept
- alu_out_mem_i  in  DATA_WIDTH  ALU result / effective address
- rs2_data_mem_i  in  DATA_WIDTH  store data
- rd_addr_mem_i  in  5  destination register
- rd_en_mem_i  in  1  register write enable
- opcode_mem_i  in  7  opcode
- funct3_mem_i  in  3  access size / sign
REQ-005 SHALL have these downstream (writeback) ports:
- valid_wb_o  out  1  result valid
- ready_wb_i  in  1  writeback can accept
- alu_out_wb_o  out  DATA_WIDTH  forwarded ALU result
- rdata_wb_o  out  DATA_WIDTH  extended load data
- rd_addr_wb_o  out  5  destination register
- rd_en_wb_o  out  1  register write enable
- opcode_wb_o  out  7  opcode
- funct3_wb_o  out  3  funct3
REQ-006 SHALL have these data-memory ports:
- dmem_req_o  out  1  request
- dmem_we_o  out  1  write
- dmem_addr_o  out  ADDR_WIDTH  8-byte-aligned address
- dmem_wdata_o  out  64  lane-aligned write data
- dmem_wstrb_o  out  8  byte strobes
- dmem_ack_i  in  1  completion
- dmem_rdata_i  in  64  read data, valid with ack

Function
REQ-007 SHALL implement the FSM IDLE -> ACCESS -> HOLD -> IDLE, with ready_mem_o=1 only in IDLE.
REQ-008 SHALL, in IDLE on valid_mem_i=1, register all upstream fields; it SHALL go to ACCESS if the opcode is LOAD (0000011) or STORE (0100011), else to HOLD.
REQ-009 SHALL, in ACCESS, hold dmem_req_o=1 with stable addr/we/wdata/wstrb until the cycle dmem_ack_i=1; on that cycle it SHALL capture the extended load data and go to HOLD.
REQ-010 SHALL drive valid_wb_o=1 in HOLD with stable outputs; on ready_wb_i=1 it SHALL return to IDLE.
REQ-011 SHALL give a non-memory instruction a latency of 1 cycle from acceptance to valid_wb_o, and a memory instruction a latency of ack cycle+1.
REQ-012 SHALL drive dmem_addr_o = {alu_out[ADDR_WIDTH-1:3],3'b000} and use byte offset = alu_out[2:0].
REQ-013 SHALL generate store strobes by funct3: SB 000 -> 1 bit at offset; SH 001 -> 2 bits; SW 010 -> 4 bits; SD 011 -> 8'hFF; wdata SHALL be rs2 shifted left by offset*8.
REQ-014 SHALL extract load data by funct3 from rdata>>(offset*8): LB/LH/LW sign-extend, LBU/LHU/LWU (100/101/110) zero-extend, LD (011) passes through.
REQ-015 SHALL ignore offset bits below the access size (SH uses offset[2:1], SW uses offset[2], SD uses 0), so misaligned accesses behave as naturally aligned.
REQ-016 SHALL force rd_en_wb_o=0 for STORE regardless of rd_en_mem_i.
REQ-017 SHALL drive rdata_wb_o=0 for non-load instructions.
REQ-018 SHALL, when valid_mem_i is asserted while not in IDLE, neither accept nor drop that input; upstream holds it.
REQ-019 SHALL ignore dmem_ack_i outside ACCESS.

Reset
REQ-020 SHALL, on rst asserted in any state including ACCESS, immediately go to IDLE and drive valid_wb_o=0, dmem_req_o=0, dmem_we_o=0, dmem_wstrb_o=0, and all data outputs 0; ready_mem_o SHALL be 1 after reset.

Structure
REQ-021 SHALL take the opcode constants (OP, LOAD, STORE), the funct3 size encodings and the FSM state enum from a shared package cprv_pkg.
REQ-022 SHALL place the store-align and load-extract logic in one sub-module, cprv_lsu_align.

Verification
REQ-023 SHALL cover: OP with alu_out=0x1234, ready_wb_i=1 -> valid_wb_o the next cycle, alu_out_wb_o=0x1234, no dmem_req_o.
REQ-024 SHALL cover: LB at addr 0x1003, dmem_rdata=0x00000000_80000000 (byte3=0x80) -> rdata_wb_o=0xFFFFFFFF_FFFFFF80; LBU gives 0x80.
REQ-025 SHALL cover: SH rs2=0xABCD at addr 0x2006 -> dmem_addr_o=0x2000, wstrb=8'hC0, wdata=0xABCD0000_00000000, rd_en_wb_o=0.
REQ-026 SHALL cover: LD with ack delayed 5 cycles and ready_wb_i low 3 cycles in HOLD -> req and outputs stable throughout, ready_mem_o=0 throughout.
REQ-027 SHALL cover: rst asserted while in ACCESS -> dmem_req_o=0 and valid_wb_o=0 that cycle, and a late ack is ignored.

Source files
------------

// File: rtl/cprv_pkg.sv
// Shared constants, control struct and FSM state for the CPRV memory stage.
package cprv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 access size / sign encodings (loads and stores share the low two bits)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } mem_state_e;

  // Control fields carried from execute to writeback.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_addr;
    logic       rd_en;
  } mem_ctl_t;

  // Drop offset bits below the access size so misaligned accesses act naturally aligned.
  function automatic logic [2:0] eff_offset(input logic [2:0] f3, input logic [2:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[2:1], 1'b0};
      2'b10:   return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cprv_lsu_align.sv
// Store lane alignment / strobe generation and load extraction / extension.
module cprv_lsu_align
  import cprv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_offset,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_ldata
);

  logic [2:0]  w_off;
  logic [5:0]  w_sh;
  logic [7:0]  w_mask;
  logic [63:0] w_rsh;

  assign w_off = eff_offset(i_funct3, i_offset);
  assign w_sh  = {w_off, 3'b000};

  // Byte mask for the access size, before shifting into the addressed lane.
  always_comb begin
    w_mask = 8'hFF;
    case (i_funct3[1:0])
      2'b00:   w_mask = 8'h01;
      2'b01:   w_mask = 8'h03;
      2'b10:   w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign o_wstrb = w_mask << w_off;
  assign o_wdata = i_wdata << w_sh;
  assign w_rsh   = i_rdata >> w_sh;

  // Extend the addressed load lane by size and signedness; LD passes through.
  always_comb begin
    o_ldata = w_rsh;
    case (i_funct3)
      F3_B:    o_ldata = {{56{w_rsh[7]}},  w_rsh[7:0]};
      F3_H:    o_ldata = {{48{w_rsh[15]}}, w_rsh[15:0]};
      F3_W:    o_ldata = {{32{w_rsh[31]}}, w_rsh[31:0]};
      F3_D:    o_ldata = w_rsh;
      F3_BU:   o_ldata = {56'd0, w_rsh[7:0]};
      F3_HU:   o_ldata = {48'd0, w_rsh[15:0]};
      F3_WU:   o_ldata = {32'd0, w_rsh[31:0]};
      default: o_ldata = w_rsh;
    endcase
  end

endmodule

// File: rtl/cprv_mem_stage.sv
// CPRV memory stage: accepts one execute result, performs at most one
// data-memory access, then holds the result for writeback.
module cprv_mem_stage
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
)(
  input  logic                  clk,
  input  logic                  rst,
  // execute side
  input  logic                  valid_mem_i,
  output logic                  ready_mem_o,
  input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
  input  logic [4:0]            rd_addr_mem_i,
  input  logic                  rd_en_mem_i,
  input  logic [6:0]            opcode_mem_i,
  input  logic [2:0]            funct3_mem_i,
  // writeback side
  output logic                  valid_wb_o,
  input  logic                  ready_wb_i,
  output logic [DATA_WIDTH-1:0] alu_out_wb_o,
  output logic [DATA_WIDTH-1:0] rdata_wb_o,
  output logic [4:0]            rd_addr_wb_o,
  output logic                  rd_en_wb_o,
  output logic [6:0]            opcode_wb_o,
  output logic [2:0]            funct3_wb_o,
  // data memory
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [63:0]           dmem_wdata_o,
  output logic [7:0]            dmem_wstrb_o,
  input  logic                  dmem_ack_i,
  input  logic [63:0]           dmem_rdata_i
);

  mem_state_e r_state, w_state_nxt;
  mem_ctl_t   r_ctl;
  logic [DATA_WIDTH-1:0] r_alu, r_rs2, r_rdata;
  logic [ADDR_WIDTH-1:0] w_alu_a;
  logic [63:0] w_wdata, w_ldata;
  logic [7:0]  w_wstrb;
  logic w_accept, w_in_mem, w_ack, w_is_load, w_is_store;

  assign w_accept   = (r_state == ST_IDLE) && valid_mem_i;
  assign w_in_mem   = (opcode_mem_i == OPC_LOAD) || (opcode_mem_i == OPC_STORE);
  assign w_ack      = (r_state == ST_ACCESS) && dmem_ack_i;
  assign w_is_load  = (r_ctl.opcode == OPC_LOAD);
  assign w_is_store = (r_ctl.opcode == OPC_STORE);
  assign w_alu_a    = ADDR_WIDTH'(r_alu);

  // State register; reset lands in IDLE from any state, including mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    ready_mem_o = 1'b0;
    valid_wb_o  = 1'b0;
    dmem_req_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_mem_o = 1'b1;
        if (valid_mem_i) w_state_nxt = w_in_mem ? ST_ACCESS : ST_HOLD;
      end
      ST_ACCESS: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        valid_wb_o = 1'b1;
        if (ready_wb_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the upstream fields on acceptance; stores never write rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu <= '0;
      r_rs2 <= '0;
      r_ctl <= '0;
    end else if (w_accept) begin
      r_alu <= alu_out_mem_i;
      r_rs2 <= rs2_data_mem_i;
      r_ctl <= '{opcode:  opcode_mem_i,
                 funct3:  funct3_mem_i,
                 rd_addr: rd_addr_mem_i,
                 rd_en:   rd_en_mem_i && (opcode_mem_i != OPC_STORE)};
    end
  end

  // Load result: cleared per instruction, filled only by the ack of a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_rdata <= '0;
    else if (w_accept)           r_rdata <= '0;
    else if (w_ack && w_is_load) r_rdata <= DATA_WIDTH'(w_ldata);
  end

  cprv_lsu_align u_align (
    .i_funct3 (r_ctl.funct3),
    .i_offset (w_alu_a[2:0]),
    .i_wdata  (64'(r_rs2)),
    .i_rdata  (dmem_rdata_i),
    .o_wdata  (w_wdata),
    .o_wstrb  (w_wstrb),
    .o_ldata  (w_ldata)
  );

  assign dmem_addr_o  = {w_alu_a[ADDR_WIDTH-1:3], 3'b000};
  assign dmem_wdata_o = w_wdata;
  assign dmem_we_o    = dmem_req_o && w_is_store;
  assign dmem_wstrb_o = (dmem_req_o && w_is_store) ? w_wstrb : 8'h00;

  assign alu_out_wb_o = r_alu;
  assign rdata_wb_o   = r_rdata;
  assign rd_addr_wb_o = r_ctl.rd_addr;
  assign rd_en_wb_o   = r_ctl.rd_en;
  assign opcode_wb_o  = r_ctl.opcode;
  assign funct3_wb_o  = r_ctl.funct3;

endmodule
